// File: rtl/rcv_pkg.sv
// Shared definitions for the receive row buffer head/tail pointer logic.
package rcv_pkg;

  localparam int DEF_DEPTH = 3;
  localparam int DEF_PTR_W = 2;

  // Pointer as seen by both the head (read) and tail (write) counters.
  typedef struct packed {
    logic                 tog;
    logic [DEF_PTR_W-1:0] idx;
  } rcv_ptr_t;

endpackage

// File: rtl/rcv_ptr_wrap.sv
// Index+toggle wrapping counter: counts 0..DEPTH-1, inverts tog on wrap.
// A load takes priority over the enable.
module rcv_ptr_wrap
  import rcv_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = DEF_PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [PTR_W-1:0] load_idx,
  input  logic             load_tog,
  output logic [PTR_W-1:0] idx,
  output logic             tog
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] idx_r;
  logic [PTR_W-1:0] idx_nxt_s;
  logic             tog_r;
  logic             tog_nxt_s;

  // Next pointer value: load, advance with wrap, or hold.
  always_comb begin
    idx_nxt_s = idx_r;
    tog_nxt_s = tog_r;
    if (load) begin
      idx_nxt_s = load_idx;
      tog_nxt_s = load_tog;
    end else if (en) begin
      if (idx_r == LAST_IDX) begin
        idx_nxt_s = {PTR_W{1'b0}};
        tog_nxt_s = ~tog_r;
      end else begin
        idx_nxt_s = idx_r + PTR_W'(1);
        tog_nxt_s = tog_r;
      end
    end else begin
      idx_nxt_s = idx_r;
      tog_nxt_s = tog_r;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= {PTR_W{1'b0}};
      tog_r <= 1'b0;
    end else begin
      idx_r <= idx_nxt_s;
      tog_r <= tog_nxt_s;
    end
  end

  assign idx = idx_r;
  assign tog = tog_r;

endmodule

// File: rtl/rcv_fifo_head_rd.sv
// Read-side controller of the receive row buffer: head pointer, status and
// registered valid/ready output stage. Define RCV_OVF_DET_EN for ovf_err.
module rcv_fifo_head_rd
  import rcv_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = DEF_PTR_W,
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PTR_W-1:0] tail_ptr,
  input  logic             tail_tog,
  input  logic [ROW_W-1:0] row_data,
  input  logic             flush,
  input  logic             out_ready,
  output logic [PTR_W-1:0] head_ptr,
  output logic             head_tog,
  output logic [ROW_W-1:0] out_data,
  output logic             out_valid,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   occupancy
`ifdef RCV_OVF_DET_EN
  ,
  output logic             ovf_err
`endif
);

  localparam logic [PTR_W:0] DEPTH_W = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] head_idx_s;
  logic             head_tog_s;
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic [PTR_W:0]   occ_s;
  logic [PTR_W:0]   head_ext_s;
  logic [PTR_W:0]   tail_ext_s;
  logic [ROW_W-1:0] out_data_r;
  logic             out_valid_r;

  rcv_ptr_wrap #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_head (
    .clk      (clk),
    .rst      (rst),
    .en       (pop_s),
    .load     (flush),
    .load_idx (tail_ptr),
    .load_tog (tail_tog),
    .idx      (head_idx_s),
    .tog      (head_tog_s)
  );

  assign head_ext_s = {1'b0, head_idx_s};
  assign tail_ext_s = {1'b0, tail_ptr};

  // Status from the registered head against the live tail.
  always_comb begin
    empty_s = (head_idx_s == tail_ptr) && (head_tog_s == tail_tog);
    full_s  = (head_idx_s == tail_ptr) && (head_tog_s != tail_tog);
    if (head_tog_s == tail_tog) begin
      occ_s = tail_ext_s - head_ext_s;
    end else begin
      occ_s = DEPTH_W - head_ext_s + tail_ext_s;
    end
  end

  assign pop_s = !empty_s && (!out_valid_r || out_ready) && !flush;

  // Output stage: flush drops it, pop reloads it, an accepted beat empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= {ROW_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (flush) begin
      out_data_r  <= out_data_r;
      out_valid_r <= 1'b0;
    end else if (pop_s) begin
      out_data_r  <= row_data;
      out_valid_r <= 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_data_r  <= out_data_r;
      out_valid_r <= 1'b0;
    end else begin
      out_data_r  <= out_data_r;
      out_valid_r <= out_valid_r;
    end
  end

  assign head_ptr  = head_idx_s;
  assign head_tog  = head_tog_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign empty     = empty_s;
  assign full      = full_s;
  assign occupancy = occ_s;

`ifdef RCV_OVF_DET_EN
  logic [PTR_W-1:0] tail_ptr_prev_r;
  logic             tail_tog_prev_r;
  logic             full_prev_r;
  logic             ovf_err_r;

  // A tail move right after a full cycle means the writer overran the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      tail_ptr_prev_r <= {PTR_W{1'b0}};
      tail_tog_prev_r <= 1'b0;
      full_prev_r     <= 1'b0;
      ovf_err_r       <= 1'b0;
    end else begin
      tail_ptr_prev_r <= tail_ptr;
      tail_tog_prev_r <= tail_tog;
      full_prev_r     <= full_s;
      if (flush) begin
        ovf_err_r <= 1'b0;
      end else if (full_prev_r &&
                   ({tail_tog, tail_ptr} != {tail_tog_prev_r, tail_ptr_prev_r})) begin
        ovf_err_r <= 1'b1;
      end else begin
        ovf_err_r <= ovf_err_r;
      end
    end
  end

  assign ovf_err = ovf_err_r;
`endif

endmodule

// File: tb/tb_rcv_fifo_head_rd.sv
// Self-checking bench for rcv_fifo_head_rd against a queue-based reference.
module tb_rcv_fifo_head_rd;

  localparam int DEPTH = 3;
  localparam int PTR_W = 2;
  localparam int ROW_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [PTR_W-1:0] tail_ptr;
  logic             tail_tog;
  logic [ROW_W-1:0] row_data;
  logic             flush;
  logic             out_ready;
  logic [PTR_W-1:0] head_ptr;
  logic             head_tog;
  logic [ROW_W-1:0] out_data;
  logic             out_valid;
  logic             empty;
  logic             full;
  logic [PTR_W:0]   occupancy;
`ifdef RCV_OVF_DET_EN
  logic             ovf_err;
`endif

  rcv_fifo_head_rd #(.DEPTH(DEPTH), .PTR_W(PTR_W), .ROW_W(ROW_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .tail_ptr  (tail_ptr),
    .tail_tog  (tail_tog),
    .row_data  (row_data),
    .flush     (flush),
    .out_ready (out_ready),
    .head_ptr  (head_ptr),
    .head_tog  (head_tog),
    .out_data  (out_data),
    .out_valid (out_valid),
    .empty     (empty),
    .full      (full),
    .occupancy (occupancy)
`ifdef RCV_OVF_DET_EN
    ,
    .ovf_err   (ovf_err)
`endif
  );

  initial forever #5 clk = ~clk;

  // Row storage model, read combinationally at the DUT's head address.
  logic [ROW_W-1:0] mem [0:3];
  assign row_data = mem[head_ptr];

  // Reference model: rows in flight, output stage and positions modulo 2*DEPTH.
  logic [ROW_W-1:0] q[$];
  int               head_pos;
  int               tail_pos;
  bit               mv;
  logic [ROW_W-1:0] md;
  bit               exp_ovf;
  bit               prev_full;

  logic             s_empty;
  logic             s_full;
  logic [PTR_W:0]   s_occ;
  int               s_size;

  int checks = 0;
  int errors = 0;

  task automatic step(input bit rs, input bit wr, input logic [ROW_W-1:0] d,
                      input bit rdy, input bit fl);
    bit pop_m;
    bit cur_full;
    if (rs) begin
      tail_pos = 0;
    end else if (wr) begin
      mem[tail_pos % DEPTH] = d;
      q.push_back(d);
      tail_pos = (tail_pos + 1) % (2 * DEPTH);
    end
    rst       = rs;
    tail_ptr  = PTR_W'(tail_pos % DEPTH);
    tail_tog  = (tail_pos >= DEPTH);
    out_ready = rdy;
    flush     = fl;
    #1;
    s_empty  = empty;
    s_full   = full;
    s_occ    = occupancy;
    s_size   = q.size();
    cur_full = (q.size() == DEPTH);
    pop_m    = (q.size() != 0) && (!mv || rdy) && !fl;
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      mv = 1'b0;
      md = '0;
      head_pos = 0;
      exp_ovf = 1'b0;
      prev_full = 1'b0;
    end else begin
      if (fl) begin
        q.delete();
        mv = 1'b0;
        head_pos = tail_pos;
      end else if (pop_m) begin
        md = q.pop_front();
        mv = 1'b1;
        head_pos = (head_pos + 1) % (2 * DEPTH);
      end else if (mv && rdy) begin
        mv = 1'b0;
      end
      if (fl) exp_ovf = 1'b0;
      else if (prev_full && wr) exp_ovf = 1'b1;
      prev_full = cur_full;
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checks++; if (head_ptr !== 2'd0 || head_tog !== 1'b0) begin errors++; $display("FAIL reset_head got %0d/%0d want 0/0", head_ptr, head_tog); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%0b full=%0b want 1/0", empty, full); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL reset_out got v=%0b d=%h want 0/00", out_valid, out_data); end
  endtask

  task automatic test_single();
    step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
    checks++; if (s_occ !== 3'd1 || s_empty !== 1'b0) begin errors++; $display("FAIL single_pre got occ=%0d empty=%0b want 1/0", s_occ, s_empty); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin errors++; $display("FAIL single_out got v=%0b d=%h want 1/a5", out_valid, out_data); end
    checks++; if (head_ptr !== 2'd1 || head_tog !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL single_head got %0d/%0d empty=%0b want 1/0 empty=1", head_ptr, head_tog, empty); end
  endtask

  task automatic test_fill_full();
    logic [ROW_W-1:0] first;
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    first = 8'($urandom);
    step(1'b0, 1'b1, first, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
    checks++; if (s_full !== 1'b1 || s_occ !== 3'd3 || s_size != DEPTH) begin errors++; $display("FAIL full_flag got full=%0b occ=%0d want 1/3", s_full, s_occ); end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_data !== first) begin errors++; $display("FAIL full_hold got v=%0b d=%h want 1/%h", out_valid, out_data, first); end
      checks++; if (head_ptr !== PTR_W'(head_pos % DEPTH) || full !== 1'b1) begin errors++; $display("FAIL full_head got %0d full=%0b want %0d full=1", head_ptr, full, head_pos % DEPTH); end
    end
  endtask

  task automatic test_drain_wrap();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (out_valid !== mv || (mv && out_data !== md)) begin errors++; $display("FAIL drain_out got v=%0b d=%h want %0b/%h", out_valid, out_data, mv, md); end
      checks++; if (head_ptr !== PTR_W'(head_pos % DEPTH) || head_tog !== (head_pos >= DEPTH)) begin errors++; $display("FAIL drain_head got %0d/%0d want %0d/%0d", head_ptr, head_tog, head_pos % DEPTH, head_pos >= DEPTH); end
    end
    checks++; if (empty !== 1'b1 || head_tog !== 1'b1) begin errors++; $display("FAIL drain_end got empty=%0b tog=%0b want 1/1", empty, head_tog); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || occupancy !== 3'd2) begin errors++; $display("FAIL flush_pre got v=%0b occ=%0d want 1/2", out_valid, occupancy); end
    step(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b0 || empty !== 1'b1 || occupancy !== 3'd0) begin errors++; $display("FAIL flush_post got v=%0b empty=%0b occ=%0d want 0/1/0", out_valid, empty, occupancy); end
    checks++; if (head_ptr !== tail_ptr || head_tog !== tail_tog) begin errors++; $display("FAIL flush_head got %0d/%0d want %0d/%0d", head_ptr, head_tog, tail_ptr, tail_tog); end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h4D, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || head_ptr !== 2'd0 || empty !== 1'b1) begin errors++; $display("FAIL reset_mid got v=%0b d=%h head=%0d empty=%0b want 0/00/0/1", out_valid, out_data, head_ptr, empty); end
  endtask

  task automatic test_random();
    bit wr;
    for (int n = 0; n < 400; n++) begin
      wr = (q.size() < DEPTH) && ($urandom_range(0, 2) != 0);
      step(1'b0, wr, 8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
      checks++; if (s_empty !== (s_size == 0) || s_full !== (s_size == DEPTH) || s_occ !== 3'(s_size)) begin errors++; $display("FAIL rand_status n=%0d got e=%0b f=%0b occ=%0d want rows=%0d", n, s_empty, s_full, s_occ, s_size); end
      checks++; if (out_valid !== mv || out_data !== md) begin errors++; $display("FAIL rand_out n=%0d got v=%0b d=%h want %0b/%h", n, out_valid, out_data, mv, md); end
      checks++; if (head_ptr !== PTR_W'(head_pos % DEPTH) || head_tog !== (head_pos >= DEPTH)) begin errors++; $display("FAIL rand_head n=%0d got %0d/%0d want %0d/%0d", n, head_ptr, head_tog, head_pos % DEPTH, head_pos >= DEPTH); end
`ifdef RCV_OVF_DET_EN
      checks++; if (ovf_err !== exp_ovf) begin errors++; $display("FAIL rand_ovf n=%0d got %0b want %0b", n, ovf_err, exp_ovf); end
`endif
    end
  endtask

`ifdef RCV_OVF_DET_EN
  task automatic test_ovf();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
    checks++; if (s_full !== 1'b1 || ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_pre got full=%0b ovf=%0b want 1/0", s_full, ovf_err); end
    step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
    checks++; if (ovf_err !== 1'b1 || exp_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", ovf_err); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", ovf_err); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", ovf_err); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; tail_ptr = '0; tail_tog = 1'b0;
    mv = 1'b0; md = '0; head_pos = 0; tail_pos = 0; exp_ovf = 1'b0; prev_full = 1'b0;
    test_reset();
    test_single();
    test_fill_full();
    test_drain_wrap();
    test_flush();
    test_reset_mid();
    test_random();
`ifdef RCV_OVF_DET_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
